// File: rtl/button_conditioner.sv
// Multi-channel push-button synchroniser, debouncer and press/release strobe generator.
// Optional hold-to-repeat on the pressed strobe is built when BUTTON_REPEAT_EN is defined.
module button_conditioner #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] in,
  output logic [NUM_BUTTONS-1:0] held,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] released
);

  // state        | meaning
  // ST_RELEASED  | button accepted as up
  // ST_PRESS_PEND| counting consecutive pushed samples
  // ST_PRESSED   | button accepted as down
  // ST_REL_PEND  | counting consecutive released samples
  localparam logic [1:0] ST_RELEASED   = 2'd0;
  localparam logic [1:0] ST_PRESS_PEND = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_REL_PEND   = 2'd3;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_BUTTONS-1:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_BUTTONS-1:0] sync1, sync2, sample;
  logic [NUM_BUTTONS-1:0] press_acc, rel_acc, rep_fire;
  logic [1:0]             state [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt   [NUM_BUTTONS];

  assign sample = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Acceptance happens on the sample that completes the stable run, so the
  // comparison is against DEBOUNCE_CYCLES-1 before the increment.
  always_comb begin
    press_acc = '0;
    rel_acc   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      case (state[i])
        ST_RELEASED:   press_acc[i] = sample[i] && (DEBOUNCE_CYCLES == 1);
        ST_PRESS_PEND: press_acc[i] = sample[i] && (cnt[i] == CNT_LAST);
        ST_PRESSED:    rel_acc[i]   = !sample[i] && (DEBOUNCE_CYCLES == 1);
        ST_REL_PEND:   rel_acc[i]   = !sample[i] && (cnt[i] == CNT_LAST);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= IDLE_LEVEL;
      sync2    <= IDLE_LEVEL;
      held     <= '0;
      pressed  <= '0;
      released <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state[i] <= ST_RELEASED;
        cnt[i]   <= '0;
      end
    end else begin
      sync1    <= in;
      sync2    <= sync1;
      pressed  <= press_acc | rep_fire;
      released <= rel_acc;
      held     <= (held | press_acc) & ~rel_acc;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (press_acc[i]) begin
          state[i] <= ST_PRESSED;
          cnt[i]   <= '0;
        end else if (rel_acc[i]) begin
          state[i] <= ST_RELEASED;
          cnt[i]   <= '0;
        end else begin
          case (state[i])
            ST_RELEASED:
              if (sample[i]) begin
                state[i] <= ST_PRESS_PEND;
                cnt[i]   <= CNT_ONE;
              end
            ST_PRESS_PEND:
              if (sample[i]) cnt[i] <= cnt[i] + CNT_ONE;
              else begin
                state[i] <= ST_RELEASED;
                cnt[i]   <= '0;
              end
            ST_PRESSED:
              if (!sample[i]) begin
                state[i] <= ST_REL_PEND;
                cnt[i]   <= CNT_ONE;
              end
            ST_REL_PEND:
              if (!sample[i]) cnt[i] <= cnt[i] + CNT_ONE;
              else begin
                state[i] <= ST_PRESSED;
                cnt[i]   <= '0;
              end
            default: begin
              state[i] <= ST_RELEASED;
              cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  logic [REP_W-1:0] rep_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] rep_run;

  // A release accepted on the same edge takes priority over a due repeat.
  always_comb begin
    rep_run  = '0;
    rep_fire = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      rep_run[i]  = ((state[i] == ST_PRESSED) || (state[i] == ST_REL_PEND)) && !rel_acc[i];
      rep_fire[i] = rep_run[i] && (rep_cnt[i] == REP_ONE);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (reset) rep_cnt[i] <= '0;
      else if (press_acc[i]) rep_cnt[i] <= REP_W'(REPEAT_DELAY);
      else if (rep_fire[i]) rep_cnt[i] <= REP_W'(REPEAT_PERIOD);
      else if (rep_run[i]) rep_cnt[i] <= rep_cnt[i] - REP_ONE;
      else rep_cnt[i] <= '0;
    end
  end
`else
  assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected strobes are queued with their due cycle
// when stimulus is applied and compared every cycle against the DUT outputs.
module tb_button_conditioner;
  localparam int N = 4;
  localparam int LAT = 6;  // drive at negedge before edge E, accept at E+5
  localparam int REP_DELAY = 8;
  localparam int REP_PERIOD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] in = 4'hF;
  logic [N-1:0] held, pressed, released;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BUTTONS(N), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(REP_DELAY), .REPEAT_PERIOD(REP_PERIOD)
  ) dut (
    .clk(clk), .reset(reset), .in(in),
    .held(held), .pressed(pressed), .released(released)
  );

  typedef struct {
    int cyc;
    logic [N-1:0] p;
    logic [N-1:0] r;
  } ev_t;

  ev_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int pc;
  logic [N-1:0] exp_held = '0;
  logic [N-1:0] ep, er;

  // Scoreboard checker: pops events due this cycle, otherwise expects quiet strobes.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    ep = '0;
    er = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        ep |= q[i].p;
        er |= q[i].r;
        q.delete(i);
      end
    end
    exp_held = (exp_held | ep) & ~er;
    checks++;
    assert (pressed === ep) else begin
      errors++;
      $error("FAIL pressed cyc=%0d observed=%b expected=%b", cyc, pressed, ep);
    end
    checks++;
    assert (released === er) else begin
      errors++;
      $error("FAIL released cyc=%0d observed=%b expected=%b", cyc, released, er);
    end
    checks++;
    assert (held === exp_held) else begin
      errors++;
      $error("FAIL held cyc=%0d observed=%b expected=%b", cyc, held, exp_held);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int c, input logic [N-1:0] p, input logic [N-1:0] r);
    ev_t e;
    e.cyc = c;
    e.p = p;
    e.r = r;
    q.push_back(e);
  endtask

  task automatic push_release(input logic [N-1:0] m, input int press_cyc, input int rel_cyc);
`ifdef BUTTON_REPEAT_EN
    for (int t = press_cyc + REP_DELAY; t < rel_cyc; t += REP_PERIOD) push_ev(t, m, '0);
`endif
    push_ev(rel_cyc, '0, m);
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    step(3);

    // clean press and release on channel 0
    in[0] = 1'b0;
    pc = cyc + LAT;
    push_ev(pc, 4'b0001, '0);
    step(20);
    in[0] = 1'b1;
    push_release(4'b0001, pc, cyc + LAT);
    step(10);

    // bounce on channel 1: low 3, high 1, then low for good
    in[1] = 1'b0;
    step(3);
    in[1] = 1'b1;
    step(1);
    in[1] = 1'b0;
    pc = cyc + LAT;
    push_ev(pc, 4'b0010, '0);
    step(12);
    in[1] = 1'b1;
    push_release(4'b0010, pc, cyc + LAT);
    step(10);

    // all channels together
    in = 4'h0;
    pc = cyc + LAT;
    push_ev(pc, 4'hF, '0);
    step(12);
    in = 4'hF;
    push_release(4'hF, pc, cyc + LAT);
    step(10);

    // reset lands on the second counted sample of channel 2
    in[2] = 1'b0;
    step(3);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    pc = cyc + LAT;
    push_ev(pc, 4'b0100, '0);
    step(12);
    in[2] = 1'b1;
    push_release(4'b0100, pc, cyc + LAT);
    step(10);

`ifdef BUTTON_REPEAT_EN
    in[0] = 1'b0;
    pc = cyc + LAT;
    push_ev(pc, 4'b0001, '0);
    step(30);
    in[0] = 1'b1;
    push_release(4'b0001, pc, cyc + LAT);
    step(10);
`endif

    for (int k = 0; k < 100 && q.size() > 0; k++) step(1);
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain observed=%0d pending expected=0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
